solar_tracker: RTL and testbench

SOLAR_TRACKER -- requirements
Module: solar_tracker

---
 rtl/solar_pkg.sv | 17 +
 rtl/step_pulser.sv | 46 ++++
 rtl/solar_tracker.sv | 154 +++++++++++++++
 tb/tb_solar_tracker.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/solar_pkg.sv
// Shared state encoding and default tuning values for the two-axis solar tracker.
package solar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EVAL    = 3'd1,
    ST_STEP_AZ = 3'd2,
    ST_STEP_EL = 3'd3,
    ST_SETTLE  = 3'd4
  } state_t;

  localparam logic [15:0] DEF_DEADBAND      = 16'd64;
  localparam logic [15:0] DEF_STEP_PERIOD   = 16'd50000;
  localparam logic [23:0] DEF_SETTLE_CYCLES = 24'd1000000;
  localparam logic [11:0] DEF_MAX_STEPS     = 12'd2048;

endpackage

// File: rtl/step_pulser.sv
// One motor step: STEP_PERIOD cycles long, pulse high for the first half,
// done asserted combinationally on the final cycle.
module step_pulser
  import solar_pkg::*;
#(
  parameter logic [15:0] STEP_PERIOD = DEF_STEP_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic pulse,
  output logic done
);

  localparam logic [15:0] HALF = STEP_PERIOD >> 1;

  logic        r_active;
  logic [15:0] r_cnt;
  logic        r_pulse;
  logic [15:0] w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + 16'd1;
  assign done      = r_active && (r_cnt == (STEP_PERIOD - 16'd1));
  assign pulse     = r_pulse;

  // Pulse is registered so an asynchronous reset drops it immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active <= 1'b0;
      r_cnt    <= 16'd0;
      r_pulse  <= 1'b0;
    end else if (start) begin
      r_active <= 1'b1;
      r_cnt    <= 16'd0;
      r_pulse  <= (HALF != 16'd0);
    end else if (done) begin
      r_active <= 1'b0;
      r_cnt    <= 16'd0;
      r_pulse  <= 1'b0;
    end else if (r_active) begin
      r_cnt    <= w_cnt_nxt;
      r_pulse  <= (w_cnt_nxt < HALF);
    end
  end

endmodule

// File: rtl/solar_tracker.sv
// Two-axis solar tracker: compares opposing light sensors and steps the
// azimuth or elevation motor toward the brighter side, one step per sample.
module solar_tracker
  import solar_pkg::*;
#(
  parameter logic [15:0] DEADBAND      = DEF_DEADBAND,
  parameter logic [15:0] STEP_PERIOD   = DEF_STEP_PERIOD,
  parameter logic [23:0] SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter logic [11:0] MAX_STEPS     = DEF_MAX_STEPS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [15:0] n_lux,
  input  logic [15:0] e_lux,
  input  logic [15:0] s_lux,
  input  logic [15:0] w_lux,
  output logic        az_step,
  output logic        el_step,
  output logic        az_dir,
  output logic        el_dir,
  output logic [11:0] az_pos,
  output logic [11:0] el_pos,
  output logic        az_limit,
  output logic        el_limit,
  output logic        busy
);

  state_t      r_state;
  logic [15:0] r_n, r_e, r_s, r_w;
  logic        r_az_dir, r_el_dir;
  logic [11:0] r_az_pos, r_el_pos;
  logic [23:0] r_settle_cnt;

  logic signed [16:0] w_diff_ew, w_diff_ns;
  logic        w_dir_az, w_dir_el;
  logic        w_go_az, w_go_el;
  logic        w_start_az, w_start_el;
  logic        w_done_az, w_done_el;

  function automatic logic [16:0] mag17(input logic signed [16:0] d);
    logic [16:0] u;
    u = d;
    return d[16] ? (~u + 17'd1) : u;
  endfunction

  function automatic logic at_limit(input logic dir, input logic [11:0] pos);
    return dir ? (pos == MAX_STEPS) : (pos == 12'd0);
  endfunction

  // Saturating move keeps the position from ever wrapping.
  function automatic logic [11:0] move(input logic dir, input logic [11:0] pos);
    if (dir) return (pos == MAX_STEPS) ? pos : pos + 12'd1;
    else     return (pos == 12'd0)     ? pos : pos - 12'd1;
  endfunction

  assign w_diff_ew = $signed({1'b0, r_e}) - $signed({1'b0, r_w});
  assign w_diff_ns = $signed({1'b0, r_n}) - $signed({1'b0, r_s});
  assign w_dir_az  = ~w_diff_ew[16];
  assign w_dir_el  = ~w_diff_ns[16];
  assign w_go_az   = (mag17(w_diff_ew) > {1'b0, DEADBAND}) && !at_limit(w_dir_az, r_az_pos);
  assign w_go_el   = (mag17(w_diff_ns) > {1'b0, DEADBAND}) && !at_limit(w_dir_el, r_el_pos);

  // Azimuth wins when both axes qualify.
  assign w_start_az = (r_state == ST_EVAL) && w_go_az;
  assign w_start_el = (r_state == ST_EVAL) && !w_go_az && w_go_el;

  step_pulser #(.STEP_PERIOD(STEP_PERIOD)) u_az_pulser (
    .clk   (clk),
    .rst   (rst),
    .start (w_start_az),
    .pulse (az_step),
    .done  (w_done_az)
  );

  step_pulser #(.STEP_PERIOD(STEP_PERIOD)) u_el_pulser (
    .clk   (clk),
    .rst   (rst),
    .start (w_start_el),
    .pulse (el_step),
    .done  (w_done_el)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_n          <= 16'd0;
      r_e          <= 16'd0;
      r_s          <= 16'd0;
      r_w          <= 16'd0;
      r_az_dir     <= 1'b0;
      r_el_dir     <= 1'b0;
      r_az_pos     <= MAX_STEPS >> 1;
      r_el_pos     <= MAX_STEPS >> 1;
      r_settle_cnt <= 24'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (sample_valid && enable) begin
            r_n     <= n_lux;
            r_e     <= e_lux;
            r_s     <= s_lux;
            r_w     <= w_lux;
            r_state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (w_go_az) begin
            r_az_dir <= w_dir_az;
            r_state  <= ST_STEP_AZ;
          end else if (w_go_el) begin
            r_el_dir <= w_dir_el;
            r_state  <= ST_STEP_EL;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_STEP_AZ: begin
          if (w_done_az) begin
            r_az_pos     <= move(r_az_dir, r_az_pos);
            r_settle_cnt <= 24'd0;
            r_state      <= ST_SETTLE;
          end
        end
        ST_STEP_EL: begin
          if (w_done_el) begin
            r_el_pos     <= move(r_el_dir, r_el_pos);
            r_settle_cnt <= 24'd0;
            r_state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if ((r_settle_cnt + 24'd1) >= SETTLE_CYCLES) begin
            r_settle_cnt <= 24'd0;
            r_state      <= ST_IDLE;
          end else begin
            r_settle_cnt <= r_settle_cnt + 24'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign az_dir   = r_az_dir;
  assign el_dir   = r_el_dir;
  assign az_pos   = r_az_pos;
  assign el_pos   = r_el_pos;
  assign az_limit = (r_az_pos == 12'd0) || (r_az_pos == MAX_STEPS);
  assign el_limit = (r_el_pos == 12'd0) || (r_el_pos == MAX_STEPS);
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_solar_tracker.sv
// Bench for solar_tracker with short step/settle timing: decision table,
// timing sequences for the corner cases, and a randomized run against a timeline model.
module tb_solar_tracker;

  localparam int DB   = 64;
  localparam int SP   = 8;
  localparam int SC   = 20;
  localparam int MAXS = 16;
  localparam int HALF = SP / 2;
  localparam int NR   = 1500;
  localparam int NA   = NR + 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] n_lux = 16'd0, e_lux = 16'd0, s_lux = 16'd0, w_lux = 16'd0;
  logic        az_step, el_step, az_dir, el_dir, az_limit, el_limit, busy;
  logic [11:0] az_pos, el_pos;

  int checks = 0;
  int failures = 0;

  bit m_busy[NA], m_azs[NA], m_els[NA], m_azd[NA], m_eld[NA];
  int m_azp[NA], m_elp[NA];
  int idle_from;

  typedef struct {
    logic [15:0] n, e, s, w;
    int          axis;
    logic        dir;
  } vec_t;

  solar_tracker #(
    .DEADBAND(16'd64), .STEP_PERIOD(16'd8), .SETTLE_CYCLES(24'd20), .MAX_STEPS(12'd16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .n_lux(n_lux), .e_lux(e_lux), .s_lux(s_lux), .w_lux(w_lux),
    .az_step(az_step), .el_step(el_step), .az_dir(az_dir), .el_dir(el_dir),
    .az_pos(az_pos), .el_pos(el_pos), .az_limit(az_limit), .el_limit(el_limit),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #4;
  endtask

  task automatic set_lux(input int n, input int e, input int s, input int w);
    n_lux = 16'(n); e_lux = 16'(e); s_lux = 16'(s); w_lux = 16'(w);
  endtask

  task automatic do_reset();
    rst = 1'b0; sample_valid = 1'b0; enable = 1'b0;
    set_lux(0, 0, 0, 0);
    repeat (2) next_cycle();
    rst = 1'b1;
    enable = 1'b1;
    next_cycle();
  endtask

  function automatic bit lim(input int p);
    return (p == 0) || (p == MAXS);
  endfunction

  function automatic int near(input int base);
    int d;
    case ($urandom_range(0, 3))
      0: d = int'($urandom_range(0, 200)) - 100;
      1: d = ($urandom_range(0, 1) != 0) ? 64 : -64;
      2: d = ($urandom_range(0, 1) != 0) ? 65 : -65;
      default: d = int'($urandom_range(0, 65535)) - base;
    endcase
    d = base + d;
    if (d < 0) d = 0;
    if (d > 65535) d = 65535;
    return d;
  endfunction

  // Timeline model: an accepted sample schedules its effects on future cycles.
  task automatic model_accept(input int r, input int nv, input int ev, input int sv, input int wv);
    int  dew, dns, ax, np;
    bit  d;
    dew = ev - wv;
    dns = nv - sv;
    ax = 0;
    d = 1'b0;
    if ((dew > DB || -dew > DB) && !((dew > 0) ? (m_azp[r] == MAXS) : (m_azp[r] == 0))) begin
      ax = 1; d = (dew > 0);
    end else if ((dns > DB || -dns > DB) && !((dns > 0) ? (m_elp[r] == MAXS) : (m_elp[r] == 0))) begin
      ax = 2; d = (dns > 0);
    end
    m_busy[r+1] = 1'b1;
    if (ax == 0) begin
      idle_from = r + 2;
    end else begin
      for (int k = r + 1; k <= r + 1 + SP + SC; k++) m_busy[k] = 1'b1;
      for (int k = r + 2; k <= r + 1 + HALF; k++) begin
        if (ax == 1) m_azs[k] = 1'b1; else m_els[k] = 1'b1;
      end
      np = (ax == 1) ? m_azp[r] : m_elp[r];
      np = d ? np + 1 : np - 1;
      for (int k = r + 2; k < NA; k++) begin
        if (ax == 1) m_azd[k] = d; else m_eld[k] = d;
      end
      for (int k = r + 2 + SP; k < NA; k++) begin
        if (ax == 1) m_azp[k] = np; else m_elp[k] = np;
      end
      idle_from = r + 2 + SP + SC;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    int   n_az, n_el, exp_az, exp_el;
    int   rn, re, rs, rw, bew, bns;
    bit   rsv, ren;
    logic [31:0] act, expv;

    tbl[0]  = '{n:16'd500,   e:16'd1000,  s:16'd500, w:16'd900,   axis:1, dir:1'b1};
    tbl[1]  = '{n:16'd500,   e:16'd564,   s:16'd500, w:16'd500,   axis:0, dir:1'b0};
    tbl[2]  = '{n:16'd500,   e:16'd565,   s:16'd500, w:16'd500,   axis:1, dir:1'b1};
    tbl[3]  = '{n:16'd500,   e:16'd500,   s:16'd500, w:16'd565,   axis:1, dir:1'b0};
    tbl[4]  = '{n:16'd1000,  e:16'd1000,  s:16'd0,   w:16'd0,     axis:1, dir:1'b1};
    tbl[5]  = '{n:16'd800,   e:16'd500,   s:16'd500, w:16'd500,   axis:2, dir:1'b1};
    tbl[6]  = '{n:16'd500,   e:16'd700,   s:16'd565, w:16'd700,   axis:2, dir:1'b0};
    tbl[7]  = '{n:16'd500,   e:16'd300,   s:16'd564, w:16'd300,   axis:0, dir:1'b0};
    tbl[8]  = '{n:16'd0,     e:16'd0,     s:16'd0,   w:16'd65535, axis:1, dir:1'b0};
    tbl[9]  = '{n:16'd65535, e:16'd12345, s:16'd0,   w:16'd12345, axis:2, dir:1'b1};
    tbl[10] = '{n:16'd436,   e:16'd436,   s:16'd500, w:16'd500,   axis:0, dir:1'b0};

    // Reset state
    repeat (2) next_cycle();
    chk("rst_az_step", 32'(az_step), 32'd0);
    chk("rst_el_step", 32'(el_step), 32'd0);
    chk("rst_az_dir", 32'(az_dir), 32'd0);
    chk("rst_el_dir", 32'(el_dir), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_az_pos", 32'(az_pos), 32'd8);
    chk("rst_el_pos", 32'(el_pos), 32'd8);
    chk("rst_limits", {30'd0, az_limit, el_limit}, 32'd0);
    rst = 1'b1;
    next_cycle();
    chk("post_rst_busy", 32'(busy), 32'd0);
    set_lux(500, 1000, 500, 900);
    enable = 1'b0;
    sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    chk("disabled_sample_busy", 32'(busy), 32'd0);

    // Decision table
    for (int i = 0; i < 11; i++) begin
      do_reset();
      n_lux = tbl[i].n; e_lux = tbl[i].e; s_lux = tbl[i].s; w_lux = tbl[i].w;
      sample_valid = 1'b1;
      next_cycle();
      sample_valid = 1'b0;
      chk($sformatf("tbl%0d_eval_busy", i), 32'(busy), 32'd1);
      next_cycle();
      chk($sformatf("tbl%0d_az_step", i), 32'(az_step), 32'(tbl[i].axis == 1));
      chk($sformatf("tbl%0d_el_step", i), 32'(el_step), 32'(tbl[i].axis == 2));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].axis != 0));
      chk($sformatf("tbl%0d_az_dir", i), 32'(az_dir), (tbl[i].axis == 1) ? 32'(tbl[i].dir) : 32'd0);
      chk($sformatf("tbl%0d_el_dir", i), 32'(el_dir), (tbl[i].axis == 2) ? 32'(tbl[i].dir) : 32'd0);
      repeat (8) next_cycle();
      exp_az = (tbl[i].axis == 1) ? (tbl[i].dir ? 9 : 7) : 8;
      exp_el = (tbl[i].axis == 2) ? (tbl[i].dir ? 9 : 7) : 8;
      chk($sformatf("tbl%0d_az_pos", i), 32'(az_pos), 32'(exp_az));
      chk($sformatf("tbl%0d_el_pos", i), 32'(el_pos), 32'(exp_el));
    end

    // Azimuth step timeline
    do_reset();
    set_lux(500, 1000, 500, 900);
    sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      chk($sformatf("az_seq_k%0d_step", k), 32'(az_step), 32'(k >= 2 && k <= 5));
      chk($sformatf("az_seq_k%0d_el_step", k), 32'(el_step), 32'd0);
      chk($sformatf("az_seq_k%0d_busy", k), 32'(busy), 32'(k <= 29));
      chk($sformatf("az_seq_k%0d_pos", k), 32'(az_pos), (k >= 10) ? 32'd9 : 32'd8);
      if (k == 2) chk("az_seq_dir", 32'(az_dir), 32'd1);
      next_cycle();
    end

    // Deadband boundary followed by one count over
    do_reset();
    set_lux(500, 564, 500, 500);
    sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    chk("db_eval_busy", 32'(busy), 32'd1);
    next_cycle();
    chk("db_idle_busy", 32'(busy), 32'd0);
    chk("db_no_step", 32'(az_step), 32'd0);
    e_lux = 16'd565;
    sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    chk("db1_eval_busy", 32'(busy), 32'd1);
    next_cycle();
    chk("db1_step", 32'(az_step), 32'd1);
    repeat (8) next_cycle();
    chk("db1_pos", 32'(az_pos), 32'd9);
    repeat (20) next_cycle();
    chk("db1_busy_end", 32'(busy), 32'd0);

    // Priority and ignored strobes
    do_reset();
    set_lux(1000, 1000, 0, 0);
    sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    n_az = 0; n_el = 0;
    for (int k = 1; k <= 31; k++) begin
      if (az_step) n_az++;
      if (el_step) n_el++;
      sample_valid = (k == 3 || k == 12 || k == 20 || k == 29);
      next_cycle();
    end
    sample_valid = 1'b0;
    chk("prio_az_cycles", 32'(n_az), 32'd4);
    chk("prio_el_cycles", 32'(n_el), 32'd0);
    chk("prio_az_pos", 32'(az_pos), 32'd9);
    chk("prio_el_pos", 32'(el_pos), 32'd8);
    chk("prio_busy", 32'(busy), 32'd0);

    // Travel limit
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_lux(500, 1000, 500, 900);
      sample_valid = 1'b1;
      next_cycle();
      sample_valid = 1'b0;
      repeat (30) next_cycle();
    end
    chk("lim_az_pos", 32'(az_pos), 32'd16);
    chk("lim_az_limit", 32'(az_limit), 32'd1);
    chk("lim_el_limit", 32'(el_limit), 32'd0);
    set_lux(800, 1000, 500, 900);
    sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    n_az = 0; n_el = 0;
    for (int k = 1; k <= 31; k++) begin
      if (az_step) n_az++;
      if (el_step) n_el++;
      next_cycle();
    end
    chk("lim_blocked_az", 32'(n_az), 32'd0);
    chk("lim_el_cycles", 32'(n_el), 32'd4);
    chk("lim_el_pos", 32'(el_pos), 32'd9);
    chk("lim_el_dir", 32'(el_dir), 32'd1);
    chk("lim_az_hold", 32'(az_pos), 32'd16);
    set_lux(500, 900, 500, 1000);
    sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    repeat (31) next_cycle();
    chk("lim_back_pos", 32'(az_pos), 32'd15);
    chk("lim_back_limit", 32'(az_limit), 32'd0);
    chk("lim_back_dir", 32'(az_dir), 32'd0);

    // Reset on the second cycle of az_step
    do_reset();
    set_lux(500, 1000, 500, 900);
    sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    next_cycle();
    next_cycle();
    chk("mid_rst_step_before", 32'(az_step), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_step_async", 32'(az_step), 32'd0);
    chk("mid_rst_busy_async", 32'(busy), 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    chk("mid_rst_az_pos", 32'(az_pos), 32'd8);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    n_az = 0;
    for (int k = 0; k < 12; k++) begin
      if (az_step) n_az++;
      next_cycle();
    end
    chk("mid_rst_no_resume", 32'(n_az), 32'd0);

    // Randomized run against the timeline model
    do_reset();
    for (int i = 0; i < NA; i++) begin
      m_busy[i] = 1'b0; m_azs[i] = 1'b0; m_els[i] = 1'b0;
      m_azd[i] = 1'b0;  m_eld[i] = 1'b0;
      m_azp[i] = 8;     m_elp[i] = 8;
    end
    idle_from = 0;
    for (int r = 0; r < NR; r++) begin
      act  = {1'b0, busy, az_step, el_step, az_dir, el_dir, az_limit, el_limit, az_pos, el_pos};
      expv = {1'b0, m_busy[r], m_azs[r], m_els[r], m_azd[r], m_eld[r],
              lim(m_azp[r]), lim(m_elp[r]), 12'(m_azp[r]), 12'(m_elp[r])};
      chk($sformatf("rand_c%0d", r), act, expv);
      rsv = ($urandom_range(0, 4) == 0);
      ren = ($urandom_range(0, 7) != 0);
      bew = int'($urandom_range(0, 65535));
      bns = int'($urandom_range(0, 65535));
      re = near(bew); rw = bew;
      rn = near(bns); rs = bns;
      set_lux(rn, re, rs, rw);
      sample_valid = rsv;
      enable = ren;
      if (r >= idle_from && rsv && ren) model_accept(r, rn, re, rs, rw);
      next_cycle();
    end
    sample_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
